bp_cce_cfg_link_responder: RTL

- Target end of the CCE config link: accepts address/data writes and reads, and returns read data.
- Owns the CCE mode register, a sticky error flag, and a committed-write counter.
- Assembles 32-bit link words into full-width CCE instructions and writes them into the instruction RAM port.
- Sits inside the ME, opposite the config loader.

---
 rtl/bp_cce_cfg_link_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/bp_cce_cfg_link_responder.sv
// bp_cce_cfg_link_responder: config link target owning CCE mode, error flag, write count and instruction RAM writes
module bp_cce_cfg_link_responder #(
  parameter int cfg_link_addr_width_p = 16,
  parameter int cfg_link_data_width_p = 32,
  parameter int inst_width_p = 48,
  parameter int inst_ram_addr_width_p = 8,
  parameter int inst_ram_els_p = 256,
  localparam int addr_w = cfg_link_addr_width_p - 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic freeze_i,
  input  logic [addr_w-1:0] config_addr_i,
  input  logic [cfg_link_data_width_p-1:0] config_data_i,
  input  logic config_v_i,
  input  logic config_w_i,
  output logic config_ready_o,
  output logic [cfg_link_data_width_p-1:0] config_data_o,
  output logic config_v_o,
  input  logic config_ready_i,
  output logic inst_ram_v_o,
  output logic inst_ram_w_o,
  output logic [inst_ram_addr_width_p-1:0] inst_ram_addr_o,
  output logic [inst_width_p-1:0] inst_ram_data_o,
  input  logic [inst_width_p-1:0] inst_ram_data_i,
  output logic cce_mode_o
);
  localparam int idx_w = inst_ram_addr_width_p;
  localparam logic [idx_w:0] els_l = (idx_w+1)'(inst_ram_els_p);
  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_e;
  state_e state;
  logic mode_r, err_r, hold_v_r, half_r;
  logic [15:0] wcount_r;
  logic [31:0] hold_data_r, resp_data_r, reg_rd;
  logic [idx_w-1:0] hold_idx_r, idx;
  logic acc, inst_sel, legal, hi, pair_ok;
  logic [63:0] ram_ext;
  always_comb begin
    acc = config_v_i & config_ready_o & ~reset_i;
    inst_sel = config_addr_i[addr_w-1];
    idx = config_addr_i[idx_w:1];
    hi = config_addr_i[0];
    legal = freeze_i & ({1'b0, idx} < els_l);
    pair_ok = hold_v_r & (hold_idx_r == idx);
    inst_ram_v_o = acc & inst_sel & legal & (~config_w_i | (hi & pair_ok));
    inst_ram_w_o = inst_ram_v_o & config_w_i;
    inst_ram_addr_o = inst_ram_v_o ? idx : '0;
    inst_ram_data_o = inst_ram_w_o ? {config_data_i[inst_width_p-33:0], hold_data_r} : '0;
    ram_ext = 64'(inst_ram_data_i);
    reg_rd = (config_addr_i == addr_w'(0)) ? {31'b0, mode_r}
           : (config_addr_i == addr_w'(1)) ? {31'b0, err_r}
           : (config_addr_i == addr_w'(2)) ? {16'b0, wcount_r} : '0;
  end
  assign config_ready_o = (state == IDLE);
  assign config_v_o = (state == RESP);
  assign config_data_o = resp_data_r;
  assign cce_mode_o = mode_r;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      mode_r <= 1'b0;
      err_r <= 1'b0;
      hold_v_r <= 1'b0;
      half_r <= 1'b0;
      wcount_r <= '0;
      hold_data_r <= '0;
      hold_idx_r <= '0;
      resp_data_r <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          if (!inst_sel) begin
            if (config_w_i) begin
              if (config_addr_i == addr_w'(0)) mode_r <= config_data_i[0];
              if (config_addr_i == addr_w'(1) && config_data_i[0]) err_r <= 1'b0;
            end else begin
              resp_data_r <= reg_rd;
              state <= RESP;
            end
          end else if (!legal) begin
            err_r <= 1'b1;
            if (!config_w_i) begin
              resp_data_r <= '0;
              state <= RESP;
            end
          end else if (!config_w_i) begin
            half_r <= hi;
            state <= RAM_WAIT;
          end else if (!hi) begin
            hold_data_r <= config_data_i;
            hold_idx_r <= idx;
            hold_v_r <= 1'b1;
          end else if (pair_ok) begin
            hold_v_r <= 1'b0;
            wcount_r <= wcount_r + 16'd1;
          end else err_r <= 1'b1;
        end
        RAM_WAIT: begin
          resp_data_r <= half_r ? ram_ext[63:32] : ram_ext[31:0];
          state <= RESP;
        end
        RESP: if (config_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
